playback_reader: RTL and testbench

//  Read-side address/data sequencer for playback in the recorder datapath.
//  On start, reads rec_len samples from sample BRAM at addresses 0..rec_len-1,

---
 rtl/playback_reader_pkg.sv | 14 +
 rtl/playback_reader_if.sv | 31 +++
 rtl/playback_reader_fifo.sv | 60 ++++++
 rtl/playback_reader.sv | 126 ++++++++++++
 tb/tb_playback_reader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/playback_reader_pkg.sv
// Shared types and default widths for the playback read-side sequencer.
package playback_reader_pkg;

    localparam int PB_ADDR_W = 17;
    localparam int PB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pb_state_t;

endpackage

// File: rtl/playback_reader_if.sv
// Bundles the BRAM read port and the sample stream toward the serializer.
// The master modport is the reader; the slave modport is the memory/serializer side.
interface playback_reader_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/playback_reader_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data_o while
// non-empty. Reading and writing in the same cycle is allowed even when full.
// Data reads back as zero while empty so stale entries never leak out.
module playback_reader_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_wr, do_rd;

    // Qualify the strobes and compute the next occupancy.
    always_comb begin
        do_rd   = rd_en_i && (count_q != '0);
        do_wr   = wr_en_i && ((count_q < CNT_W'(DEPTH)) || do_rd);
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; flush empties the buffer in one cycle.
    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_wr && !reset && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/playback_reader.sv
// Playback read sequencer: walks sample BRAM from address 0 to rec_len-1,
// tracks reads in flight through the fixed BRAM latency, parks returned samples
// in a show-ahead FIFO and hands them to the serializer with valid/ready.
// Reads are throttled so buffered plus in-flight samples never exceed the FIFO.
module playback_reader
    import playback_reader_pkg::*;
#(
    parameter int ADDR_W     = PB_ADDR_W,
    parameter int DATA_W     = PB_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [ADDR_W-1:0] rec_len_i,
    output logic              busy_o,
    output logic              done_o,
    playback_reader_if.master pb_if
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    pb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] issued_q, issued_d;
    logic [ADDR_W-1:0] xfer_q, xfer_d;
    logic [RD_LAT-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]  fifo_cnt, inflight;
    logic [CNT_W:0]    occupancy;
    logic              rd_en, xfer, flush, fifo_empty, fifo_wr;

    assign flush = stop_i && ((state_q == FETCH) || (state_q == DRAIN));
    assign xfer  = pb_if.sample_valid && pb_if.sample_ready;

    // Count reads still travelling through the BRAM pipe and gate new reads.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(tag_q[i]);
        occupancy = {1'b0, fifo_cnt} + {1'b0, inflight};
        rd_en = (state_q == FETCH) && (issued_q < len_q) &&
                (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    end

    // Shift read tags toward the tail; an abort drops every in-flight return.
    always_comb begin
        tag_d = '0;
        if (!flush) begin
            tag_d[0] = rd_en;
            for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
        end
    end

    assign fifo_wr = tag_q[RD_LAT-1] && !flush;

    // Next-state logic plus length latch and issue/transfer counters.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q + ADDR_W'(rd_en);
        xfer_d   = xfer_q + ADDR_W'(xfer);
        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    len_d    = rec_len_i;
                    issued_d = '0;
                    xfer_d   = '0;
                    state_d  = (rec_len_i == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (flush)
                    state_d = IDLE;
                else if (rd_en && (issued_q == len_q - ADDR_W'(1)))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (flush)
                    state_d = IDLE;
                else if (xfer && (xfer_q == len_q - ADDR_W'(1)))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counter and in-flight registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issued_q <= '0;
            xfer_q   <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            xfer_q   <= xfer_d;
            tag_q    <= tag_d;
        end
    end

    playback_reader_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush_i   (flush),
        .wr_en_i   (fifo_wr),
        .wr_data_i (pb_if.mem_rd_data),
        .rd_en_i   (xfer),
        .rd_data_o (pb_if.sample_data),
        .empty_o   (fifo_empty),
        .count_o   (fifo_cnt)
    );

    assign pb_if.mem_rd_en    = rd_en;
    assign pb_if.mem_rd_addr  = issued_q;
    assign pb_if.sample_valid = !fifo_empty;
    assign busy_o             = (state_q == FETCH) || (state_q == DRAIN);
    assign done_o             = (state_q == DONE);

endmodule

// File: tb/tb_playback_reader.sv
// Bench for playback_reader: instance A uses RD_LAT=1, instance B RD_LAT=2,
// both with FIFO_DEPTH=4. Memory contents are a salted hash of the address.
module tb_playback_reader;
    localparam int AW = 17;
    localparam int DW = 16;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          start_a = 1'b0, stop_a = 1'b0, busy_a, done_a;
    logic          start_b = 1'b0, stop_b = 1'b0, busy_b, done_b;
    logic [AW-1:0] len_a = '0, len_b = '0;

    playback_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    playback_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    playback_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) dut_a (
        .clock(clock), .reset(reset), .start_i(start_a), .stop_i(stop_a),
        .rec_len_i(len_a), .busy_o(busy_a), .done_o(done_a), .pb_if(bus_a));

    playback_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .FIFO_DEPTH(DEPTH)) dut_b (
        .clock(clock), .reset(reset), .start_i(start_b), .stop_i(stop_b),
        .rec_len_i(len_b), .busy_o(busy_b), .done_o(done_b), .pb_if(bus_b));

    int unsigned salt = 32'h1234_5678;
    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        logic [31:0] t;
        t = ({15'd0, a} * 32'd40503) ^ salt;
        return t[DW-1:0];
    endfunction

    // BRAM models: data appears RD_LAT cycles after the strobe, junk otherwise.
    logic [DW-1:0] ma_q = '0, mb_q1 = '0, mb_q2 = '0;
    always @(posedge clock) begin
        ma_q  <= bus_a.mem_rd_en ? memf(bus_a.mem_rd_addr) : 16'hDEAD;
        mb_q1 <= bus_b.mem_rd_en ? memf(bus_b.mem_rd_addr) : 16'hDEAD;
        mb_q2 <= mb_q1;
    end
    assign bus_a.mem_rd_data = ma_q;
    assign bus_b.mem_rd_data = mb_q2;

    logic          o_rd, o_v, o_busy, o_done;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;

    task automatic tick_a(input logic st, input logic sp, input logic rdy);
        @(posedge clock); #1;
        start_a = st; stop_a = sp; bus_a.sample_ready = rdy;
        @(negedge clock);
        o_rd = bus_a.mem_rd_en; o_addr = bus_a.mem_rd_addr; o_v = bus_a.sample_valid;
        o_data = bus_a.sample_data; o_busy = busy_a; o_done = done_a;
    endtask

    task automatic tick_b(input logic st, input logic sp, input logic rdy);
        @(posedge clock); #1;
        start_b = st; stop_b = sp; bus_b.sample_ready = rdy;
        @(negedge clock);
        o_rd = bus_b.mem_rd_en; o_addr = bus_b.mem_rd_addr; o_v = bus_b.sample_valid;
        o_data = bus_b.sample_data; o_busy = busy_b; o_done = done_b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick_a(1'b0, 1'b0, 1'b0);
        n_vec++; if (o_rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got %b exp 0", o_rd); end
        n_vec++; if (o_addr !== '0) begin n_bad++; $display("FAIL reset_addr got %0h exp 0", o_addr); end
        n_vec++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", o_v); end
        n_vec++; if (o_data !== '0) begin n_bad++; $display("FAIL reset_data got %0h exp 0", o_data); end
        n_vec++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        n_vec++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", o_done); end
        n_vec++; if ({busy_b, done_b, bus_b.sample_valid, bus_b.mem_rd_en} !== 4'b0) begin
            n_bad++; $display("FAIL reset_b got %b exp 0000", {busy_b, done_b, bus_b.sample_valid, bus_b.mem_rd_en}); end
        reset = 1'b0;
    endtask

    // Fixed-timing run: reads @T+1..T+5, samples @T+3..T+7, done @T+8.
    task automatic test_basic();
        len_a = AW'(5);
        tick_a(1'b1, 1'b0, 1'b1);
        n_vec++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_T got %b exp 0", o_busy); end
        for (int c = 1; c <= 9; c++) begin
            tick_a(1'b0, 1'b0, 1'b1);
            n_vec++; if (o_rd !== (c >= 1 && c <= 5)) begin n_bad++; $display("FAIL basic_rd_en c=%0d got %b", c, o_rd); end
            if (o_rd) begin
                n_vec++; if (o_addr !== AW'(c - 1)) begin n_bad++; $display("FAIL basic_addr c=%0d got %0d exp %0d", c, o_addr, c - 1); end
            end
            n_vec++; if (o_v !== (c >= 3 && c <= 7)) begin n_bad++; $display("FAIL basic_valid c=%0d got %b", c, o_v); end
            if (o_v && c >= 3) begin
                n_vec++; if (o_data !== memf(AW'(c - 3))) begin n_bad++; $display("FAIL basic_data c=%0d got %0h exp %0h", c, o_data, memf(AW'(c - 3))); end
            end
            n_vec++; if (o_busy !== (c <= 7)) begin n_bad++; $display("FAIL basic_busy c=%0d got %b", c, o_busy); end
            n_vec++; if (o_done !== (c == 8)) begin n_bad++; $display("FAIL basic_done c=%0d got %b", c, o_done); end
        end
    endtask

    // Random ready: reads throttled by outstanding samples, order kept, stalls stable.
    task automatic test_backpressure();
        int reads = 0, xf = 0;
        logic fin = 1'b0, prev_stall = 1'b0, rdy, exp_rd;
        logic [DW-1:0] prev_data = '0;
        len_a = AW'(8);
        tick_a(1'b1, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            rdy = 1'($urandom_range(0, 1));
            tick_a(1'b0, 1'b0, rdy);
            exp_rd = (xf != 8) && (reads < 8) && (reads - xf < DEPTH);
            n_vec++; if (o_rd !== exp_rd) begin n_bad++; $display("FAIL bp_rd_en cyc=%0d got %b exp %b", cyc, o_rd, exp_rd); end
            if (o_rd) begin
                n_vec++; if (o_addr !== AW'(reads)) begin n_bad++; $display("FAIL bp_addr got %0d exp %0d", o_addr, reads); end
            end
            if (prev_stall) begin
                n_vec++; if ({o_v, o_data} !== {1'b1, prev_data}) begin n_bad++; $display("FAIL bp_stall got %b/%0h exp 1/%0h", o_v, o_data, prev_data); end
            end
            if (o_v) begin
                n_vec++; if ((xf < reads) !== 1'b1) begin n_bad++; $display("FAIL bp_extra_valid xf=%0d reads=%0d", xf, reads); end
            end
            if (o_v && rdy) begin
                n_vec++; if (o_data !== memf(AW'(xf))) begin n_bad++; $display("FAIL bp_data idx=%0d got %0h exp %0h", xf, o_data, memf(AW'(xf))); end
                xf++;
            end
            n_vec++; if (o_done !== (xf == 8 && !(o_v && rdy))) begin n_bad++; $display("FAIL bp_done cyc=%0d got %b", cyc, o_done); end
            if (o_done) fin = 1'b1;
            prev_stall = o_v && !rdy;
            prev_data  = o_data;
            if (o_rd) reads++;
        end
        n_vec++; if (fin !== 1'b1) begin n_bad++; $display("FAIL bp_timeout done got %b exp 1", fin); end
        n_vec++; if (reads !== 8) begin n_bad++; $display("FAIL bp_reads got %0d exp 8", reads); end
        tick_a(1'b0, 1'b0, 1'b1);
        n_vec++; if ({o_done, o_busy} !== 2'b00) begin n_bad++; $display("FAIL bp_after got %b exp 00", {o_done, o_busy}); end
    endtask

    task automatic test_zero();
        len_a = '0;
        tick_a(1'b1, 1'b0, 1'b1);
        tick_a(1'b0, 1'b0, 1'b1);
        n_vec++; if ({o_done, o_busy, o_rd} !== 3'b100) begin n_bad++; $display("FAIL zero_T1 got %b exp 100", {o_done, o_busy, o_rd}); end
        tick_a(1'b0, 1'b0, 1'b1);
        n_vec++; if ({o_done, o_busy, o_rd} !== 3'b000) begin n_bad++; $display("FAIL zero_T2 got %b exp 000", {o_done, o_busy, o_rd}); end
    endtask

    task automatic test_start_stop();
        len_a = AW'(7);
        tick_a(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick_a(1'b0, 1'b0, 1'b1);
            n_vec++; if ({o_busy, o_rd, o_v, o_done} !== 4'b0) begin n_bad++; $display("FAIL startstop k=%0d got %b exp 0000", k, {o_busy, o_rd, o_v, o_done}); end
        end
        len_a = '0;
        tick_a(1'b1, 1'b1, 1'b1);
        tick_a(1'b0, 1'b0, 1'b1);
        n_vec++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL startstop_zero_done got %b exp 0", o_done); end
    endtask

    // Abort after 10 transfers, then a fresh start replays from address 0.
    task automatic test_stop();
        int xf = 0, reads = 0;
        logic fin = 1'b0;
        len_a = AW'(100);
        tick_a(1'b1, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 50 && xf < 10; cyc++) begin
            tick_a(1'b0, 1'b0, 1'b1);
            if (o_v) begin
                n_vec++; if (o_data !== memf(AW'(xf))) begin n_bad++; $display("FAIL stop_data idx=%0d got %0h", xf, o_data); end
                xf++;
            end
        end
        tick_a(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick_a(1'b0, 1'b0, 1'b1);
            n_vec++; if ({o_v, o_busy, o_done, o_rd} !== 4'b0) begin n_bad++; $display("FAIL stop_after k=%0d got %b exp 0000", k, {o_v, o_busy, o_done, o_rd}); end
        end
        len_a = AW'(4); xf = 0;
        tick_a(1'b1, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
            tick_a(1'b0, 1'b0, 1'b1);
            if (o_rd) begin
                n_vec++; if (o_addr !== AW'(reads)) begin n_bad++; $display("FAIL replay_addr got %0d exp %0d", o_addr, reads); end
                reads++;
            end
            if (o_v) begin
                n_vec++; if (o_data !== memf(AW'(xf))) begin n_bad++; $display("FAIL replay_data idx=%0d got %0h exp %0h", xf, o_data, memf(AW'(xf))); end
                xf++;
            end
            if (o_done) fin = 1'b1;
        end
        n_vec++; if ({fin, 3'(xf), 3'(reads)} !== {1'b1, 3'd4, 3'd4}) begin n_bad++; $display("FAIL replay_end done=%b xf=%0d reads=%0d exp 1/4/4", fin, xf, reads); end
    endtask

    // A second start with a shorter length while busy must be ignored.
    task automatic test_while_busy();
        int reads = 0, xf = 0;
        logic fin = 1'b0, rdy, st;
        len_a = AW'(50);
        tick_a(1'b1, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            rdy = ($urandom_range(0, 3) != 0);
            st  = (cyc == 6);
            if (st) len_a = AW'(3);
            tick_a(st, 1'b0, rdy);
            if (o_rd) begin
                n_vec++; if (o_addr !== AW'(reads)) begin n_bad++; $display("FAIL busy_addr got %0d exp %0d", o_addr, reads); end
                reads++;
            end
            if (o_v && rdy) begin
                n_vec++; if (o_data !== memf(AW'(xf))) begin n_bad++; $display("FAIL busy_data idx=%0d got %0h exp %0h", xf, o_data, memf(AW'(xf))); end
                xf++;
            end
            if (o_done) begin
                fin = 1'b1;
                n_vec++; if (xf !== 50) begin n_bad++; $display("FAIL busy_done_at xf=%0d exp 50", xf); end
            end
        end
        n_vec++; if ({fin, 6'(reads)} !== {1'b1, 6'd50}) begin n_bad++; $display("FAIL busy_end done=%b reads=%0d exp 1/50", fin, reads); end
    endtask

    // RD_LAT=2 instance: first sample valid @T+4, full sequence in order.
    task automatic test_lat2();
        int reads = 0, xf = 0, first_v = -1;
        logic fin = 1'b0, exp_rd;
        len_b = AW'(16);
        tick_b(1'b1, 1'b0, 1'b1);
        for (int c = 1; c < 80 && !fin; c++) begin
            tick_b(1'b0, 1'b0, 1'b1);
            exp_rd = (xf != 16) && (reads < 16) && (reads - xf < DEPTH);
            n_vec++; if (o_rd !== exp_rd) begin n_bad++; $display("FAIL lat2_rd_en c=%0d got %b exp %b", c, o_rd, exp_rd); end
            if (o_v && first_v < 0) first_v = c;
            if (o_v) begin
                n_vec++; if (o_data !== memf(AW'(xf))) begin n_bad++; $display("FAIL lat2_data idx=%0d got %0h exp %0h", xf, o_data, memf(AW'(xf))); end
                xf++;
            end
            n_vec++; if (o_done !== (xf == 16 && !o_v)) begin n_bad++; $display("FAIL lat2_done c=%0d got %b", c, o_done); end
            if (o_done) fin = 1'b1;
            if (o_rd) reads++;
        end
        n_vec++; if (first_v !== 4) begin n_bad++; $display("FAIL lat2_first_valid got T+%0d exp T+4", first_v); end
        n_vec++; if (fin !== 1'b1) begin n_bad++; $display("FAIL lat2_timeout done got %b exp 1", fin); end
    endtask

    task automatic test_reset_mid();
        len_a = AW'(20);
        tick_a(1'b1, 1'b0, 1'b1);
        repeat (6) tick_a(1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick_a(1'b0, 1'b0, 1'b1);
        n_vec++; if ({o_rd, o_v, o_busy, o_done, o_addr, o_data} !== '0) begin
            n_bad++; $display("FAIL rstmid got rd=%b v=%b busy=%b done=%b addr=%0h data=%0h exp all 0", o_rd, o_v, o_busy, o_done, o_addr, o_data); end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick_a(1'b0, 1'b0, 1'b1);
            n_vec++; if ({o_rd, o_v, o_busy, o_done} !== 4'b0) begin n_bad++; $display("FAIL rstmid_after k=%0d got %b exp 0000", k, {o_rd, o_v, o_busy, o_done}); end
        end
    endtask

    initial begin
        salt = $urandom;
        bus_a.sample_ready = 1'b0;
        bus_b.sample_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_start_stop();
        test_stop();
        test_while_busy();
        test_lat2();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
